// File: rtl/ula_writeback.sv
// ULA result/writeback stage: 2-entry skid FIFO to the register-file write port,
// architectural {N,Z,C,V} flag register and committed-write counter.
// Optional: define ULA_STICKY_FLAGS_EN to make C and V sticky until flag_clear/reset.
module ula_writeback #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_setflags,
  input  logic                  in_zero,
  input  logic                  in_carry,
  input  logic                  in_overflow,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  wb_en,
  output logic [3:0]            flags,
  input  logic                  flag_clear,
  output logic [CNT_W-1:0]      wb_count
);

  logic [DATA_W-1:0]     mem_data [2];
  logic [REG_ADDR_W-1:0] mem_addr [2];
  logic                  mem_en   [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            count_nxt;
  logic                  push;
  logic                  pop;

  // in_ready depends on registered occupancy only, so there is no
  // combinational path from wb_ready back to the ULA.
  assign in_ready = (count != 2'd2);
  assign wb_valid = (count != 2'd0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;

  assign wb_data = mem_data[rd_ptr];
  assign wb_addr = mem_addr[rd_ptr];
  assign wb_en   = wb_valid && mem_en[rd_ptr];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: the two storage entries are reset because the head drives wb_data/wb_addr, which must read 0 out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
        mem_en[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_data[wr_ptr] <= in_result;
      mem_addr[wr_ptr] <= in_rd;
      // r0 writes still occupy a slot but never assert the write enable.
      mem_en[wr_ptr]   <= in_wen && (in_rd != '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flags <= 4'b0000;
    end else if (flag_clear) begin
      flags <= 4'b0000;
    end else if (push && in_setflags) begin
`ifdef ULA_STICKY_FLAGS_EN
      flags <= {in_result[DATA_W-1], in_zero, flags[1] | in_carry, flags[0] | in_overflow};
`else
      flags <= {in_result[DATA_W-1], in_zero, in_carry, in_overflow};
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_count <= '0;
    end else if (pop && wb_en) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end

endmodule
